// File: rtl/mc_datapath_regs.sv
// rtl/mc_datapath_regs.sv - multicycle MIPS datapath state: PC, IR, MDR, A, B, ALUOut, register file
module mc_datapath_regs #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             IorD,
  input  logic             IRwrite,
  input  logic             pcwrite,
  input  logic             branch,
  input  logic             regwrite,
  input  logic             regdst,
  input  logic             memtoreg,
  input  logic             alusrcA,
  input  logic [1:0]       alusrcB,
  input  logic [1:0]       pcsrc,
  input  logic [WIDTH-1:0] readdata,
  input  logic [WIDTH-1:0] aluresult,
  input  logic             zero,
  output logic [WIDTH-1:0] adr,
  output logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] srca,
  output logic [WIDTH-1:0] srcb,
  output logic [5:0]       op,
  output logic [5:0]       funct,
  output logic [WIDTH-1:0] pc
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic [WIDTH-1:0] mdr_q, mdr_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] aluout_q, aluout_d;
  logic [WIDTH-1:0] rf_q [32];
  logic [WIDTH-1:0] rf_d [32];

  logic             pcen;
  logic [4:0]       rs_addr, rt_addr, waddr;
  logic [WIDTH-1:0] rs_data, rt_data, wdata;
  logic [WIDTH-1:0] signimm;
  logic [WIDTH-1:0] jump_target;

  assign pcen        = pcwrite | (branch & zero);
  assign rs_addr     = ir_q[25:21];
  assign rt_addr     = ir_q[20:16];
  assign waddr       = regdst ? ir_q[15:11] : ir_q[20:16];
  assign wdata       = memtoreg ? mdr_q : aluout_q;
  assign signimm     = {{(WIDTH-16){ir_q[15]}}, ir_q[15:0]};
  assign jump_target = {pc_q[WIDTH-1:WIDTH-4], ir_q[25:0], 2'b00};

  // Register file read: r0 is hard-wired to zero, no write-to-read bypass.
  always_comb begin
    rs_data = (rs_addr == 5'd0) ? '0 : rf_q[rs_addr];
    rt_data = (rt_addr == 5'd0) ? '0 : rf_q[rt_addr];
  end

  // Next-state for PC, IR and the free-running pipeline registers.
  always_comb begin
    pc_d = pc_q;
    if (pcen) begin
      unique case (pcsrc)
        2'b00:   pc_d = aluresult;
        2'b01:   pc_d = aluout_q;
        2'b10:   pc_d = jump_target;
        default: pc_d = pc_q;
      endcase
    end
    ir_d     = IRwrite ? readdata : ir_q;
    mdr_d    = readdata;
    a_d      = rs_data;
    b_d      = rt_data;
    aluout_d = aluresult;
  end

  // Register file write: writes to r0 are dropped so it always reads zero.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      rf_d[i] = rf_q[i];
    end
    if (regwrite && (waddr != 5'd0)) begin
      rf_d[waddr] = wdata;
    end
  end

  // State registers; reset wins over every enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      mdr_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      mdr_q    <= mdr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluout_q <= aluout_d;
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  // Operand selection and outputs toward memory, ALU and control FSM.
  always_comb begin
    adr  = IorD ? aluout_q : pc_q;
    srca = alusrcA ? a_q : pc_q;
    unique case (alusrcB)
      2'b00:   srcb = b_q;
      2'b01:   srcb = WIDTH'(4);
      2'b10:   srcb = signimm;
      default: srcb = {signimm[WIDTH-3:0], 2'b00};
    endcase
    writedata = b_q;
    op        = ir_q[31:26];
    funct     = ir_q[5:0];
    pc        = pc_q;
  end

endmodule

// File: tb/tb_mc_datapath_regs.sv
// tb/tb_mc_datapath_regs.sv - vector-table and scoreboard bench for mc_datapath_regs
module tb_mc_datapath_regs;

  typedef struct {
    logic        rst, iord, irw, pcw, br, rw, rd, m2r, asa;
    logic [1:0]  asb, psrc;
    logic [31:0] rdata, ares;
    logic        z;
    logic [31:0] epc, eadr, esrca, esrcb, ewd;
    logic [5:0]  eop, efn;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, IorD, IRwrite, pcwrite, branch, regwrite, regdst, memtoreg, alusrcA, zero;
  logic [1:0]  alusrcB, pcsrc;
  logic [31:0] readdata, aluresult;
  logic [31:0] adr, writedata, srca, srcb, pc;
  logic [5:0]  op, funct;

  int checks = 0;
  int errors = 0;
  vec_t exp_q[$];
  vec_t tbl[20];

  always #5 clk = ~clk;

  mc_datapath_regs #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .IorD(IorD), .IRwrite(IRwrite), .pcwrite(pcwrite),
    .branch(branch), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
    .alusrcA(alusrcA), .alusrcB(alusrcB), .pcsrc(pcsrc), .readdata(readdata),
    .aluresult(aluresult), .zero(zero), .adr(adr), .writedata(writedata),
    .srca(srca), .srcb(srcb), .op(op), .funct(funct), .pc(pc)
  );

  function automatic vec_t v(
    input logic rst, iord, irw, pcw, br, rw, rd, m2r, asa,
    input logic [1:0] asb, psrc, input logic [31:0] rdata, ares, input logic z,
    input logic [31:0] epc, eadr, esrca, esrcb, ewd, input logic [5:0] eop, efn);
    vec_t r;
    r.rst = rst; r.iord = iord; r.irw = irw; r.pcw = pcw; r.br = br; r.rw = rw;
    r.rd = rd; r.m2r = m2r; r.asa = asa; r.asb = asb; r.psrc = psrc;
    r.rdata = rdata; r.ares = ares; r.z = z;
    r.epc = epc; r.eadr = eadr; r.esrca = esrca; r.esrcb = esrcb; r.ewd = ewd;
    r.eop = eop; r.efn = efn;
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input int idx);
    vec_t e;
    reset = t.rst; IorD = t.iord; IRwrite = t.irw; pcwrite = t.pcw; branch = t.br;
    regwrite = t.rw; regdst = t.rd; memtoreg = t.m2r; alusrcA = t.asa;
    alusrcB = t.asb; pcsrc = t.psrc; readdata = t.rdata; aluresult = t.ares; zero = t.z;
    exp_q.push_back(t);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("pc", idx, pc, e.epc);
    chk("adr", idx, adr, e.eadr);
    chk("srca", idx, srca, e.esrca);
    chk("srcb", idx, srcb, e.esrcb);
    chk("writedata", idx, writedata, e.ewd);
    chk("op", idx, {26'd0, op}, {26'd0, e.eop});
    chk("funct", idx, {26'd0, funct}, {26'd0, e.efn});
  endtask

  initial begin
    //            rst iord irw pcw br rw rd m2r asa asb    psrc   rdata         ares          z   pc            adr           srca          srcb          wd            op     fn
    tbl[0]  = v(1, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0,        32'h40,       0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        6'h00, 6'h00);
    tbl[1]  = v(1, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0,        32'h40,       0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        6'h00, 6'h00);
    tbl[2]  = v(0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 32'h8C080004, 32'h4,        0, 32'h4,        32'h4,        32'h4,        32'h4,        32'h0,        6'h23, 6'h04);
    tbl[3]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'hDEADBEEF, 32'h0,        0, 32'h4,        32'h4,        32'h4,        32'h0,        32'h0,        6'h23, 6'h04);
    tbl[4]  = v(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 32'h0,        32'h0,        0, 32'h4,        32'h4,        32'h4,        32'h0,        32'h0,        6'h23, 6'h04);
    tbl[5]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0,        32'h0,        0, 32'h4,        32'h4,        32'h4,        32'hDEADBEEF, 32'hDEADBEEF, 6'h23, 6'h04);
    tbl[6]  = v(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h01000000, 32'h0,        0, 32'h4,        32'h4,        32'h4,        32'hDEADBEEF, 32'hDEADBEEF, 6'h00, 6'h00);
    tbl[7]  = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 32'h0,        32'h12345678, 0, 32'h4,        32'h4,        32'hDEADBEEF, 32'h0,        32'h0,        6'h00, 6'h00);
    tbl[8]  = v(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 32'h0,        32'h100,      0, 32'h4,        32'h4,        32'h4,        32'h0,        32'h0,        6'h00, 6'h00);
    tbl[9]  = v(0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0,        32'h100,      0, 32'h4,        32'h100,      32'h4,        32'h0,        32'h0,        6'h00, 6'h00);
    tbl[10] = v(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 32'h1000FFFF, 32'h100,      0, 32'h4,        32'h4,        32'h4,        32'hFFFFFFFC, 32'h0,        6'h04, 6'h3F);
    tbl[11] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 32'h0,        32'h100,      0, 32'h4,        32'h4,        32'h4,        32'hFFFFFFFF, 32'h0,        6'h04, 6'h3F);
    tbl[12] = v(0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b01, 32'h0,        32'h100,      0, 32'h4,        32'h4,        32'h4,        32'h0,        32'h0,        6'h04, 6'h3F);
    tbl[13] = v(0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b01, 32'h0,        32'h100,      1, 32'h100,      32'h100,      32'h100,      32'h0,        32'h0,        6'h04, 6'h3F);
    tbl[14] = v(0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b11, 32'h0,        32'h200,      0, 32'h100,      32'h100,      32'h100,      32'h0,        32'h0,        6'h04, 6'h3F);
    tbl[15] = v(0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h08000100, 32'h40000010, 0, 32'h40000010, 32'h40000010, 32'h40000010, 32'h0,        32'h0,        6'h02, 6'h00);
    tbl[16] = v(0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 32'h0,        32'h0,        0, 32'h40000400, 32'h40000400, 32'h40000400, 32'h0,        32'h0,        6'h02, 6'h00);
    tbl[17] = v(1, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0,        32'h40,       0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        6'h00, 6'h00);
    tbl[18] = v(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h00080000, 32'h0,        0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        6'h00, 6'h00);
    tbl[19] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0,        32'h0,        0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        6'h00, 6'h00);

    reset = 1'b1; IorD = 0; IRwrite = 0; pcwrite = 0; branch = 0; regwrite = 0;
    regdst = 0; memtoreg = 0; alusrcA = 0; alusrcB = 2'b00; pcsrc = 2'b00;
    readdata = '0; aluresult = '0; zero = 0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) begin
      apply(tbl[i], i);
    end

    // Hand sequence: rd-field write of ALUOut into r9, same-edge read of r9 sees the old value.
    apply(v(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h01204800, 32'hCAFE0001, 0,
            32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 6'h00, 6'h00), 100);
    apply(v(0, 0, 0, 0, 0, 1, 1, 0, 1, 2'b00, 2'b00, 32'h0, 32'h0, 0,
            32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 6'h00, 6'h00), 101);
    apply(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 32'h0, 32'h0, 0,
            32'h0, 32'h0, 32'hCAFE0001, 32'h0, 32'h0, 6'h00, 6'h00), 102);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
